// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file and its busy scoreboard.
// Holds the default geometry, the address/data typedefs and the zero-register constant.
package regfile_pkg;

    // Default geometry; instances override through their own parameters.
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    // Register 0 is hard-wired to zero and never reserved.
    localparam int ZERO_REG = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_score.sv
// Busy scoreboard for regfile_sb: one busy bit per architectural register, the
// set/clear priority between issue and writeback, and an incrementally
// maintained registered population count of the busy vector.
module regfile_sb_score
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREG-1:0]   busy,
    output logic [AW:0]       busy_cnt
);

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_nxt;
    logic            cnt_inc;
    logic [AW:0]     cnt_dec;
    logic [AW:0]     cnt_nxt;

    // Decode the issue request into a one-hot set vector; register 0 is never reserved.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        set_vec = '0;
        if (iss_en && (iss_addr != AW'(ZERO_REG))) begin
            set_vec[iss_addr] = 1'b1;
        end
    end

    // Decode all enabled writeback ports into a clear vector.
    always_comb begin
        clr_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                clr_vec[wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
        clr_vec[ZERO_REG] = 1'b0;
    end

    // Next busy vector with set-over-clear priority, plus the count delta from real transitions.
    always_comb begin
        busy_nxt = busy;
        cnt_inc  = 1'b0;
        cnt_dec  = '0;
        for (int r = 0; r < NREG; r++) begin
            if (set_vec[r]) begin
                // A new producer supersedes any in-flight writeback to the same register.
                busy_nxt[r] = 1'b1;
                if (!busy[r]) begin
                    cnt_inc = 1'b1;
                end
            end else if (clr_vec[r]) begin
                busy_nxt[r] = 1'b0;
                // Only a bit that was actually set decrements, so idle writebacks cannot underflow.
                if (busy[r]) begin
                    cnt_dec = cnt_dec + 1'b1;
                end
            end
        end
        cnt_nxt = busy_cnt + (AW+1)'(cnt_inc) - cnt_dec;
    end

    // Busy vector and its population count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with an integrated busy scoreboard.
// Decode reads operands and reserves a destination; writeback retires results and
// releases the reservation. Register 0 reads zero and is never reserved.
// Optional feature macro: REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding
// (data and busy) on the read ports; it does not affect state or busy_cnt.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] reg_we;
    logic [XLEN-1:0] reg_wd [NREG];
    logic [NREG-1:0] busy;

    // Scoreboard: busy bits and the reserved-register count.
    regfile_sb_score #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_score (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Per-register write enable and data; scanning ports upward lets the highest index win.
    always_comb begin
        reg_we = '0;
        for (int r = 0; r < NREG; r++) begin
            reg_wd[r] = '0;
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                reg_we[wr_addr[w*AW +: AW]] = 1'b1;
                reg_wd[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
        reg_we[ZERO_REG] = 1'b0;
    end

    // Flop-based data array; register 0 keeps its reset value of zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because outputs must read zero out of reset; a RAM macro could not do this.
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (reg_we[r]) begin
                    regs[r] <= reg_wd[r];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] byp_hit;

    // Read ports with same-cycle forwarding from the highest matching write port.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        byp_hit = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
            rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])
                    && (rd_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
                    rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                    byp_hit[p]              = 1'b1;
                end
            end
            // A same-cycle issue to this register keeps it busy despite the retiring write.
            if (byp_hit[p] && !(iss_en && (iss_addr == rd_addr[p*AW +: AW]))) begin
                rd_busy[p] = 1'b0;
            end
        end
    end
`else
    // Read ports return the stored value and the registered busy bit only.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
            rd_busy[p]              = busy[rd_addr[p*AW +: AW]];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default geometry: 32x32, 2 read, 2 write).
// Expectations follow the bypass macro when REGFILE_BYPASS_EN is defined.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [5:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    regfile_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_en   = 1'b0;
        iss_addr = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_rd(5'd5, 5'd7);
        #1;
        check("reset_rd0", rd_data[31:0], 32'h0);
        check("reset_busy", {30'b0, rd_busy}, 32'h0);
        check("reset_cnt", {26'b0, busy_cnt}, 32'h0);
        #11 rst_n = 1'b1;
        step();

        // Write r5 and reserve it in the same cycle, then reset asynchronously mid-cycle.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        iss_en = 1'b1; iss_addr = 5'd5;
        step();
        idle();
        #1;
        check("r5_written", rd_data[31:0], 32'hDEADBEEF);
        check("r5_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("cnt_before_rst", {26'b0, busy_cnt}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rd0", rd_data[31:0], 32'h0);
        check("async_rst_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("async_rst_cnt", {26'b0, busy_cnt}, 32'h0);
        rst_n = 1'b1;
        step();
        check("r5_after_rst", rd_data[31:0], 32'h0);
        check("cnt_after_rst", {26'b0, busy_cnt}, 32'h0);

        // Dual write collision: port 1 wins.
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        step();
        idle();
        set_rd(5'd7, 5'd7);
        #1;
        check("collision_p0", rd_data[31:0], 32'h22);
        check("collision_p1", rd_data[63:32], 32'h22);

        // Register 0: write and issue are both ignored.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        idle();
        set_rd(5'd0, 5'd0);
        #1;
        check("r0_data", rd_data[31:0], 32'h0);
        check("r0_busy", {30'b0, rd_busy}, 32'h0);
        check("r0_cnt", {26'b0, busy_cnt}, 32'h0);

        // Scoreboard: issue r3 then r4.
        set_rd(5'd3, 5'd4);
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        check("iss_r3_cnt", {26'b0, busy_cnt}, 32'h1);
        check("iss_r3_busy", {31'b0, rd_busy[0]}, 32'h1);
        iss_addr = 5'd4;
        step();
        idle();
        #1;
        check("iss_r4_cnt", {26'b0, busy_cnt}, 32'h2);
        check("iss_r4_busy", {31'b0, rd_busy[1]}, 32'h1);

        // Writeback r3 releases it.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h33};
        step();
        idle();
        #1;
        check("wb_r3_cnt", {26'b0, busy_cnt}, 32'h1);
        check("wb_r3_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("wb_r3_data", rd_data[31:0], 32'h33);

        // Issue and writeback of r4 together: bit stays set (same-cycle view too).
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0};
        #1;
        check("iss_wb_r4_same_cycle_busy", {31'b0, rd_busy[1]}, 32'h1);
        step();
        idle();
        #1;
        check("iss_wb_r4_busy", {31'b0, rd_busy[1]}, 32'h1);
        check("iss_wb_r4_cnt", {26'b0, busy_cnt}, 32'h1);
        check("iss_wb_r4_data", rd_data[63:32], 32'h44);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h45};
        step();
        idle();
        #1;
        check("r4_released_cnt", {26'b0, busy_cnt}, 32'h0);

        // Bypass: r9 holds 0x1234 and is busy, then written with 0xCAFE while read on both ports.
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h1234};
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        idle();
        set_rd(5'd9, 5'd9);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hCAFE};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_p0_data", rd_data[31:0], 32'hCAFE);
        check("bypass_p1_data", rd_data[63:32], 32'hCAFE);
        check("bypass_busy", {30'b0, rd_busy}, 32'h0);
`else
        check("nobypass_p0_data", rd_data[31:0], 32'h1234);
        check("nobypass_p1_data", rd_data[63:32], 32'h1234);
        check("nobypass_busy", {30'b0, rd_busy}, 32'h3);
`endif
        step();
        idle();
        #1;
        check("r9_next_p0", rd_data[31:0], 32'hCAFE);
        check("r9_next_p1", rd_data[63:32], 32'hCAFE);
        check("r9_next_busy", {30'b0, rd_busy}, 32'h0);
        check("r9_next_cnt", {26'b0, busy_cnt}, 32'h0);

        // Fill: reserve r1..r31.
        for (int i = 1; i < 32; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            step();
        end
        idle();
        set_rd(5'd1, 5'd31);
        #1;
        check("fill_cnt", {26'b0, busy_cnt}, 32'd31);
        check("fill_busy", {30'b0, rd_busy}, 32'h3);

        // Retire two per cycle.
        for (int i = 1; i < 32; i += 2) begin
            if (i < 31) begin
                wr_en = 2'b11; wr_addr = {5'(i + 1), 5'(i)};
                wr_data = {32'(i + 1), 32'(i)};
            end else begin
                wr_en = 2'b01; wr_addr = {5'd0, 5'(i)};
                wr_data = {32'h0, 32'(i)};
            end
            step();
            if (i == 1) check("retire_first_cnt", {26'b0, busy_cnt}, 32'd29);
        end
        idle();
        #1;
        check("retire_cnt", {26'b0, busy_cnt}, 32'd0);
        check("retire_busy", {30'b0, rd_busy}, 32'h0);
        check("retire_r31_data", rd_data[63:32], 32'd31);

        // Writeback to registers that are not busy must not underflow.
        wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'h2, 32'h1};
        step();
        idle();
        #1;
        check("no_underflow_cnt", {26'b0, busy_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
